// File: rtl/mac_accum_pkg.sv
// Shared types and default sizing for the mac_accum multiply-accumulate sequencer.
package mac_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int GUARD_DEF   = 8;
  localparam int MAX_LEN_DEF = 256;
  localparam int CNT_W_DEF   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACCUM = 2'd2,
    OUT   = 2'd3
  } state_e;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/mac_accum_add.sv
// Combinational signed accumulator adder; flags two's-complement overflow of the wrapped sum.
module acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = acc_width(WIDTH_DEF, GUARD_DEF)
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  assign sum_o = a_i + b_i;

  // Overflow only when both addends agree in sign and the result disagrees.
  assign ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (sum_o[ACC_W-1] != a_i[ACC_W-1]);

endmodule

// File: rtl/mac_accum.sv
// Sequences operand pairs through an external mul core and accumulates a signed dot product.
module mac_accum
  import mac_pkg::*;
#(
  parameter int  WIDTH   = WIDTH_DEF,
  parameter int  GUARD   = GUARD_DEF,
  parameter int  MAX_LEN = MAX_LEN_DEF,
  parameter int  CNT_W   = CNT_W_DEF,
  localparam int ACC_W   = acc_width(WIDTH, GUARD)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_a,
  input  logic signed [WIDTH-1:0]   in_b,
  input  logic                      in_last,
  output logic                      start_mul,
  output logic signed [WIDTH-1:0]   mul_a,
  output logic signed [WIDTH-1:0]   mul_b,
  input  logic signed [2*WIDTH-1:0] product,
  input  logic                      done_mul,
  output logic                      acc_valid,
  input  logic                      acc_ready,
  output logic signed [ACC_W-1:0]   acc_out,
  output logic [CNT_W-1:0]          acc_count,
  output logic                      overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN);

  state_e                    state_q;
  logic                      in_ready_q, start_q, valid_q, last_q, ovf_q;
  logic signed [WIDTH-1:0]   a_q, b_q;
  logic signed [2*WIDTH-1:0] prod_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d, prod_ext;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_d;

  // Size cast of a signed value sign-extends, which also works when GUARD is 0.
  assign prod_ext = ACC_W'(prod_q);
  assign cnt_d    = cnt_q + CNT_W'(1);

  acc_add #(.ACC_W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (acc_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (done_mul) begin
            prod_q  <= product;
            start_q <= 1'b0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          ovf_q <= ovf_q | ovf_d;
          // A vector closes on an explicit last or when it reaches MAX_LEN pairs.
          if (last_q || (cnt_d == LAST_CNT)) begin
            valid_q <= 1'b1;
            state_q <= OUT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        OUT: begin
          if (acc_ready) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign start_mul = start_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign acc_valid = valid_q;
  assign acc_out   = acc_q;
  assign acc_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: three parameterisations share one stimulus port and a random-latency mul model.
module tb_mac_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n, in_valid, in_last, acc_ready, mulDone, spurDone;
  logic signed [15:0]  in_a, in_b;
  logic signed [31:0]  product;
  logic [1:0]          sel;
  logic                done_mul;
  int                  total = 0;
  int                  bad = 0;

  assign done_mul = mulDone | spurDone;

  logic iv0, iv1, iv2, ar0, ar1, ar2, dm0, dm1, dm2;
  assign iv0 = in_valid  && (sel == 2'd0);
  assign iv1 = in_valid  && (sel == 2'd1);
  assign iv2 = in_valid  && (sel == 2'd2);
  assign ar0 = acc_ready && (sel == 2'd0);
  assign ar1 = acc_ready && (sel == 2'd1);
  assign ar2 = acc_ready && (sel == 2'd2);
  assign dm0 = done_mul  && (sel == 2'd0);
  assign dm1 = done_mul  && (sel == 2'd1);
  assign dm2 = done_mul  && (sel == 2'd2);

  logic               rdy0, rdy1, rdy2, st0, st1, st2, av0, av1, av2, ov0, ov1, ov2;
  logic signed [15:0] ma0, ma1, ma2, mb0, mb1, mb2;
  logic signed [39:0] acc0, acc2;
  logic signed [31:0] acc1;
  logic [8:0]         cnt0, cnt1, cnt2;

  mac_accum dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .start_mul(st0), .mul_a(ma0), .mul_b(mb0), .product(product),
    .done_mul(dm0), .acc_valid(av0), .acc_ready(ar0), .acc_out(acc0), .acc_count(cnt0), .overflow(ov0)
  );

  mac_accum #(.GUARD(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .start_mul(st1), .mul_a(ma1), .mul_b(mb1), .product(product),
    .done_mul(dm1), .acc_valid(av1), .acc_ready(ar1), .acc_out(acc1), .acc_count(cnt1), .overflow(ov1)
  );

  mac_accum #(.MAX_LEN(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .start_mul(st2), .mul_a(ma2), .mul_b(mb2), .product(product),
    .done_mul(dm2), .acc_valid(av2), .acc_ready(ar2), .acc_out(acc2), .acc_count(cnt2), .overflow(ov2)
  );

  // Observation of whichever instance is selected; the 32-bit accumulator is sign-extended.
  logic               in_ready_s, start_s, acc_valid_s, ovf_s;
  logic signed [15:0] mul_a_s, mul_b_s;
  logic signed [39:0] acc_s;
  logic [8:0]         cnt_s;
  assign in_ready_s  = (sel == 2'd1) ? rdy1 : (sel == 2'd2) ? rdy2 : rdy0;
  assign start_s     = (sel == 2'd1) ? st1  : (sel == 2'd2) ? st2  : st0;
  assign acc_valid_s = (sel == 2'd1) ? av1  : (sel == 2'd2) ? av2  : av0;
  assign ovf_s       = (sel == 2'd1) ? ov1  : (sel == 2'd2) ? ov2  : ov0;
  assign mul_a_s     = (sel == 2'd1) ? ma1  : (sel == 2'd2) ? ma2  : ma0;
  assign mul_b_s     = (sel == 2'd1) ? mb1  : (sel == 2'd2) ? mb2  : mb0;
  assign cnt_s       = (sel == 2'd1) ? cnt1 : (sel == 2'd2) ? cnt2 : cnt0;
  assign acc_s       = (sel == 2'd1) ? {{8{acc1[31]}}, acc1} : (sel == 2'd2) ? acc2 : acc0;

  // Behavioural mul core: random 1-10 cycle latency, one-cycle done pulse.
  initial begin
    int                 lat;
    logic               busy;
    logic signed [15:0] opa, opb;
    mulDone = 1'b0; product = '0; busy = 1'b0; lat = 0; opa = '0; opb = '0;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        busy = 1'b0;
        mulDone = 1'b0;
      end else begin
        mulDone = 1'b0;
        if (busy) begin
          lat--;
          if (lat == 0) begin
            product = opa * opb;
            mulDone = 1'b1;
            busy = 1'b0;
          end
        end else if (start_s) begin
          busy = 1'b1;
          lat = $urandom_range(1, 10);
          opa = mul_a_s;
          opb = mul_b_s;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, wanted completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (in_ready_s !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (n >= 300) begin bad++; $display("[TB] FAIL %s_ready_timeout: in_ready=%0b want 1", tag, in_ready_s); end
  endtask

  task automatic send_pair(input logic signed [15:0] a, input logic signed [15:0] b, input logic last);
    wait_idle("send");
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (start_s !== 1'b1 || in_ready_s !== 1'b0 || mul_a_s !== a || mul_b_s !== b) begin
      bad++;
      $display("[TB] FAIL issue: start=%0b rdy=%0b a=%0d b=%0d want start=1 rdy=0 a=%0d b=%0d",
               start_s, in_ready_s, mul_a_s, mul_b_s, a, b);
    end
  endtask

  task automatic get_result(output logic signed [39:0] acc, output logic [8:0] cnt, output logic ovf);
    int n;
    n = 0;
    while (acc_valid_s !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (n >= 300) begin bad++; $display("[TB] FAIL result_timeout: acc_valid=%0b want 1", acc_valid_s); end
    acc = acc_s; cnt = cnt_s; ovf = ovf_s;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (in_ready_s !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready_s); end
    total++; if (start_s !== 1'b0 || acc_valid_s !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: start=%0b valid=%0b want 0 0", start_s, acc_valid_s); end
    total++; if (acc_s !== 40'sd0 || cnt_s !== 9'd0 || ovf_s !== 1'b0) begin bad++; $display("[TB] FAIL reset_acc: acc=%0d cnt=%0d ovf=%0b want 0 0 0", acc_s, cnt_s, ovf_s); end
    total++; if (mul_a_s !== 16'sd0 || mul_b_s !== 16'sd0) begin bad++; $display("[TB] FAIL reset_operands: a=%0d b=%0d want 0 0", mul_a_s, mul_b_s); end
  endtask

  task automatic test_basic;
    logic signed [39:0] acc; logic [8:0] cnt; logic ovf;
    sel = 2'd0;
    send_pair(16'sd201, 16'sd102, 1'b0);
    send_pair(-16'sd3, 16'sd7, 1'b1);
    get_result(acc, cnt, ovf);
    total++; if (acc !== 40'sd20481 || cnt !== 9'd2 || ovf !== 1'b0) begin bad++; $display("[TB] FAIL basic: acc=%0d cnt=%0d ovf=%0b want 20481 2 0", acc, cnt, ovf); end
    total++; if (in_ready_s !== 1'b1 || acc_s !== 40'sd0 || cnt_s !== 9'd0) begin bad++; $display("[TB] FAIL basic_clear: rdy=%0b acc=%0d cnt=%0d want 1 0 0", in_ready_s, acc_s, cnt_s); end
  endtask

  task automatic test_single;
    logic signed [39:0] acc; logic [8:0] cnt; logic ovf;
    sel = 2'd0;
    send_pair(-16'sd32768, -16'sd32768, 1'b1);
    get_result(acc, cnt, ovf);
    total++; if (acc !== 40'sd1073741824 || cnt !== 9'd1 || ovf !== 1'b0) begin bad++; $display("[TB] FAIL single: acc=%0d cnt=%0d ovf=%0b want 1073741824 1 0", acc, cnt, ovf); end
  endtask

  task automatic test_overflow;
    logic signed [39:0] acc; logic [8:0] cnt; logic ovf;
    sel = 2'd1;
    send_pair(-16'sd32768, -16'sd32768, 1'b0);
    send_pair(-16'sd32768, -16'sd32768, 1'b1);
    get_result(acc, cnt, ovf);
    total++; if (acc[31:0] !== 32'h80000000 || cnt !== 9'd2) begin bad++; $display("[TB] FAIL ovf_value: acc=%h cnt=%0d want 80000000 2", acc[31:0], cnt); end
    total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %0b want 1", ovf); end
    total++; if (ovf_s !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %0b want 0", ovf_s); end
  endtask

  task automatic test_maxlen;
    logic signed [39:0] acc; logic [8:0] cnt; logic ovf;
    sel = 2'd2;
    for (int i = 0; i < 4; i++) send_pair(16'sd1, 16'sd1, 1'b0);
    get_result(acc, cnt, ovf);
    total++; if (acc !== 40'sd4 || cnt !== 9'd4) begin bad++; $display("[TB] FAIL maxlen: acc=%0d cnt=%0d want 4 4", acc, cnt); end
    send_pair(16'sd1, 16'sd1, 1'b0);
    wait_idle("maxlen");
    total++; if (acc_s !== 40'sd1 || cnt_s !== 9'd1 || acc_valid_s !== 1'b0) begin bad++; $display("[TB] FAIL maxlen_next: acc=%0d cnt=%0d valid=%0b want 1 1 0", acc_s, cnt_s, acc_valid_s); end
    send_pair(16'sd2, 16'sd2, 1'b1);
    get_result(acc, cnt, ovf);
    total++; if (acc !== 40'sd5 || cnt !== 9'd2) begin bad++; $display("[TB] FAIL maxlen_second: acc=%0d cnt=%0d want 5 2", acc, cnt); end
  endtask

  task automatic test_backpressure;
    int n;
    sel = 2'd0;
    send_pair(16'sd5, 16'sd6, 1'b1);
    n = 0;
    while (acc_valid_s !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (acc_valid_s !== 1'b1 || acc_s !== 40'sd30 || cnt_s !== 9'd1 || in_ready_s !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold_%0d: valid=%0b acc=%0d cnt=%0d rdy=%0b want 1 30 1 0", i, acc_valid_s, acc_s, cnt_s, in_ready_s);
      end
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    total++; if (in_ready_s !== 1'b1 || acc_valid_s !== 1'b0 || acc_s !== 40'sd0 || cnt_s !== 9'd0) begin bad++; $display("[TB] FAIL release: rdy=%0b valid=%0b acc=%0d cnt=%0d want 1 0 0 0", in_ready_s, acc_valid_s, acc_s, cnt_s); end
  endtask

  task automatic test_stall_spurious;
    logic signed [39:0] acc; logic [8:0] cnt; logic ovf;
    sel = 2'd0;
    send_pair(16'sd4, 16'sd5, 1'b0);
    wait_idle("stall");
    spurDone = 1'b1;
    repeat (3) @(negedge clk);
    spurDone = 1'b0;
    total++; if (acc_s !== 40'sd20 || cnt_s !== 9'd1 || start_s !== 1'b0 || in_ready_s !== 1'b1) begin bad++; $display("[TB] FAIL stall: acc=%0d cnt=%0d start=%0b rdy=%0b want 20 1 0 1", acc_s, cnt_s, start_s, in_ready_s); end
    send_pair(16'sd1, 16'sd1, 1'b1);
    get_result(acc, cnt, ovf);
    total++; if (acc !== 40'sd21 || cnt !== 9'd2) begin bad++; $display("[TB] FAIL stall_resume: acc=%0d cnt=%0d want 21 2", acc, cnt); end
  endtask

  task automatic test_reset_issue;
    logic signed [39:0] acc; logic [8:0] cnt; logic ovf;
    sel = 2'd0;
    send_pair(16'sd7, 16'sd7, 1'b0);
    send_pair(16'sd3, 16'sd3, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    total++; if (start_s !== 1'b0 || in_ready_s !== 1'b1) begin bad++; $display("[TB] FAIL async_reset: start=%0b rdy=%0b want 0 1", start_s, in_ready_s); end
    total++; if (acc_s !== 40'sd0 || cnt_s !== 9'd0) begin bad++; $display("[TB] FAIL reset_discard: acc=%0d cnt=%0d want 0 0", acc_s, cnt_s); end
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    send_pair(16'sd2, 16'sd3, 1'b1);
    get_result(acc, cnt, ovf);
    total++; if (acc !== 40'sd6 || cnt !== 9'd1 || ovf !== 1'b0) begin bad++; $display("[TB] FAIL after_reset: acc=%0d cnt=%0d ovf=%0b want 6 1 0", acc, cnt, ovf); end
  endtask

  // Reference: exact dot product in 64-bit arithmetic, wrapped to the accumulator width;
  // overflow is flagged when any running sum leaves the signed accumulator range.
  task automatic test_random;
    logic signed [39:0] acc, expAcc; logic [8:0] cnt; logic ovf, expOvf;
    logic signed [15:0] a, b;
    longint sum, lim;
    int len, accW;
    for (int v = 0; v < 16; v++) begin
      sel = (v % 2 == 0) ? 2'd0 : 2'd1;
      accW = (sel == 2'd0) ? 40 : 32;
      lim = longint'(1) <<< (accW - 1);
      len = $urandom_range(1, 6);
      sum = 0;
      expOvf = 1'b0;
      for (int i = 0; i < len; i++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_pair(a, b, (i == len - 1));
        sum += longint'(a) * longint'(b);
        if (sum >= lim || sum < -lim) expOvf = 1'b1;
      end
      expAcc = (accW == 40) ? sum[39:0] : {{8{sum[31]}}, sum[31:0]};
      repeat ($urandom_range(0, 4)) @(negedge clk);
      get_result(acc, cnt, ovf);
      total++;
      if (acc !== expAcc || cnt !== 9'(len) || ovf !== expOvf) begin
        bad++;
        $display("[TB] FAIL random_%0d: acc=%0d cnt=%0d ovf=%0b want %0d %0d %0b", v, acc, cnt, ovf, expAcc, len, expOvf);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_ready = 1'b0;
    spurDone = 1'b0; in_a = '0; in_b = '0; sel = 2'd0;
    repeat (2) @(negedge clk);
    test_reset;
    #1 reset_n = 1'b1;
    @(negedge clk);
    test_basic;
    test_single;
    test_overflow;
    test_maxlen;
    test_backpressure;
    test_stall_spurious;
    test_reset_issue;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
